// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for a single shared W-bit register, with optional
// bounded lock sessions that let one requester own several consecutive writes.
//
//   state  | meaning
//   IDLE   | round-robin arbitration starting at ptr
//   LOCKED | only owner may write; session ends on lock/req drop or MAX_HOLD grants
module shared_reg_arbiter #(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         lock,
   input  logic [N*W-1:0]       wdata,
   output logic [N-1:0]         gnt,
   output logic [W-1:0]         q,
   output logic                 q_valid,
   output logic [$clog2(N)-1:0] owner,
   output logic                 locked
);

   localparam int PW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD + 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [HW-1:0]   hold_cnt;
   logic            sel_valid;
   logic [PW-1:0]   sel_idx;
   logic [PW-1:0]   next_ptr;
   int unsigned     scan_idx;
   logic [W-1:0]    wdata_arr [N];

   for (genvar i = 0; i < N; i++) begin : g_unpack
      assign wdata_arr[i] = wdata[i*W +: W];
   end

   // In LOCKED only the owner is considered; otherwise scan ptr, ptr+1, ... mod N.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      scan_idx  = 0;
      if (state == LOCKED) begin
         sel_valid = req[owner];
         sel_idx   = owner;
      end else begin
         for (int k = 0; k < N; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= N) scan_idx = scan_idx - N;
            if (!sel_valid && req[PW'(scan_idx)]) begin
               sel_valid = 1'b1;
               sel_idx   = PW'(scan_idx);
            end
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (!reset && sel_valid) gnt[sel_idx] = 1'b1;
   end

   assign next_ptr = (sel_idx == PW'(N - 1)) ? '0 : sel_idx + 1'b1;
   assign locked   = (state == LOCKED);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         q        <= '0;
         q_valid  <= 1'b0;
         owner    <= '0;
      end else begin
         q_valid <= sel_valid;
         if (sel_valid) begin
            q     <= wdata_arr[sel_idx];
            owner <= sel_idx;
         end
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  ptr <= next_ptr;
                  if (lock[sel_idx] && MAX_HOLD > 1) begin
                     state    <= LOCKED;
                     hold_cnt <= HW'(1);
                  end
               end
            end
            LOCKED: begin
               // ptr already points past the owner, so a released owner ranks last.
               if (sel_valid && lock[sel_idx] && (int'(hold_cnt) + 1 < MAX_HOLD)) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end else begin
                  state    <= IDLE;
                  hold_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus random
// traffic compared against a lock-session model of the arbiter.
module tb_shared_reg_arbiter;

   localparam int N        = 4;
   localparam int W        = 8;
   localparam int MAX_HOLD = 4;
   localparam int PW       = 2;

   logic           clk   = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req   = '0;
   logic [N-1:0]   lock  = '0;
   logic [N*W-1:0] wdata = '0;
   logic [N-1:0]   gnt;
   logic [W-1:0]   q;
   logic           q_valid;
   logic [PW-1:0]  owner;
   logic           locked;

   shared_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
      .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .locked(locked)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a session is a run of consecutive grants to one requester.
   int           m_ptr, m_owner, m_session;
   bit           m_locked, m_qv;
   logic [W-1:0] m_q;
   logic [N-1:0] exp_gnt;

   function automatic int model_grant();
      if (reset) return -1;
      if (m_locked) return req[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++) begin
         if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_commit();
      int g;
      g = model_grant();
      if (reset) begin
         m_ptr = 0; m_owner = 0; m_session = 0; m_locked = 0; m_qv = 0; m_q = '0;
      end else if (g >= 0) begin
         m_q       = wdata[g*W +: W];
         m_qv      = 1;
         m_owner   = g;
         m_ptr     = (g + 1) % N;
         m_session = m_locked ? m_session + 1 : 1;
         m_locked  = lock[g] && (m_session < MAX_HOLD);
         if (!m_locked) m_session = 0;
      end else begin
         m_qv = 0; m_locked = 0; m_session = 0;
      end
   endtask

   // Inputs change on the falling edge; everything is sampled 1ns later.
   task automatic drive(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l,
                        input logic [N*W-1:0] d);
      int g;
      model_commit();
      @(negedge clk);
      reset = rst; req = r; lock = l; wdata = d;
      #1;
      g = model_grant();
      exp_gnt = (g < 0) ? '0 : (N'(1) << g);
   endtask

   function automatic logic [N*W-1:0] pat();
      logic [N*W-1:0] d;
      for (int i = 0; i < N; i++) d[i*W +: W] = W'(8'h10 + i);
      return d;
   endfunction

   task automatic do_reset();
      drive(1'b1, '1, '0, pat());
      drive(1'b1, '1, '0, pat());
   endtask

   task automatic test_reset();
      drive(1'b1, 4'b1111, 4'b0000, pat());
      n_checks++;
      if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt0 got %b want 0000", gnt); end
      drive(1'b1, 4'b1111, 4'b0000, pat());
      n_checks++;
      if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt1 got %b want 0000", gnt); end
      drive(1'b0, 4'b0000, 4'b0000, pat());
      n_checks++;
      if ({q, q_valid, owner, locked} !== '0)
         begin n_fail++; $display("FAIL reset_state got q=%h qv=%b own=%0d lk=%b want all 0", q, q_valid, owner, locked); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] rr_exp [5];
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 4'b1111, 4'b0000, pat());
         n_checks++;
         if (gnt !== rr_exp[k]) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, rr_exp[k]); end
         if (k > 0) begin
            n_checks++;
            if (q !== W'(8'h10 + (k - 1) % 4) || q_valid !== 1'b1)
               begin n_fail++; $display("FAIL rr_q[%0d] got %h/%b want %h/1", k, q, q_valid, 8'h10 + (k - 1) % 4); end
         end
      end
      drive(1'b0, 4'b0000, 4'b0000, pat());
      n_checks++;
      if (q !== 8'h10 || q_valid !== 1'b1 || gnt !== 4'b0000)
         begin n_fail++; $display("FAIL rr_tail got q=%h qv=%b gnt=%b want 10/1/0000", q, q_valid, gnt); end
   endtask

   task automatic test_sparse();
      do_reset();
      drive(1'b0, 4'b0100, 4'b0000, pat());
      n_checks++;
      if (gnt !== 4'b0100) begin n_fail++; $display("FAIL sparse_gnt2 got %b want 0100", gnt); end
      drive(1'b0, 4'b1010, 4'b0000, pat());
      n_checks++;
      if (gnt !== 4'b1000 || owner !== 2'd2)
         begin n_fail++; $display("FAIL sparse_gnt3 got %b own=%0d want 1000 own=2", gnt, owner); end
      drive(1'b0, 4'b1010, 4'b0000, pat());
      n_checks++;
      if (gnt !== 4'b0010 || owner !== 2'd3)
         begin n_fail++; $display("FAIL sparse_wrap got %b own=%0d want 0010 own=3", gnt, owner); end
      drive(1'b0, 4'b0000, 4'b0000, pat());
      n_checks++;
      if (owner !== 2'd1 || q !== 8'h11)
         begin n_fail++; $display("FAIL sparse_end got own=%0d q=%h want 1/11", owner, q); end
   endtask

   task automatic test_lock_session();
      do_reset();
      drive(1'b0, 4'b1111, 4'b0000, pat());
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 4'b1111, 4'b0010, pat());
         n_checks++;
         if (gnt !== 4'b0010 || locked !== (k >= 1))
            begin n_fail++; $display("FAIL lock_hold[%0d] got gnt=%b lk=%b want 0010/%0d", k, gnt, locked, k >= 1); end
      end
      drive(1'b0, 4'b1111, 4'b0010, pat());
      n_checks++;
      if (gnt !== 4'b0100 || locked !== 1'b0)
         begin n_fail++; $display("FAIL lock_max got gnt=%b lk=%b want 0100/0", gnt, locked); end
   endtask

   task automatic test_lock_release();
      do_reset();
      drive(1'b0, 4'b0001, 4'b0000, pat());
      drive(1'b0, 4'b1111, 4'b0010, pat());
      drive(1'b0, 4'b1111, 4'b0010, pat());
      drive(1'b0, 4'b1111, 4'b0000, pat());
      n_checks++;
      if (gnt !== 4'b0010 || locked !== 1'b1)
         begin n_fail++; $display("FAIL rel_lock_last got gnt=%b lk=%b want 0010/1", gnt, locked); end
      drive(1'b0, 4'b0100, 4'b0000, pat());
      n_checks++;
      if (gnt !== 4'b0100 || locked !== 1'b0)
         begin n_fail++; $display("FAIL rel_lock_next got gnt=%b lk=%b want 0100/0", gnt, locked); end
      do_reset();
      drive(1'b0, 4'b0001, 4'b0000, pat());
      drive(1'b0, 4'b0010, 4'b0010, pat());
      drive(1'b0, 4'b0010, 4'b0010, pat());
      drive(1'b0, 4'b1101, 4'b1111, pat());
      n_checks++;
      if (gnt !== 4'b0000 || locked !== 1'b1)
         begin n_fail++; $display("FAIL rel_req_drop got gnt=%b lk=%b want 0000/1", gnt, locked); end
      drive(1'b0, 4'b1101, 4'b0000, pat());
      n_checks++;
      if (q_valid !== 1'b0 || locked !== 1'b0 || gnt !== 4'b0100)
         begin n_fail++; $display("FAIL rel_req_after got qv=%b lk=%b gnt=%b want 0/0/0100", q_valid, locked, gnt); end
   endtask

   task automatic test_reset_mid_lock();
      do_reset();
      drive(1'b0, 4'b1000, 4'b1000, pat());
      drive(1'b0, 4'b1000, 4'b1000, pat());
      drive(1'b1, 4'b1111, 4'b1111, pat());
      n_checks++;
      if (gnt !== 4'b0000 || locked !== 1'b1 || owner !== 2'd3)
         begin n_fail++; $display("FAIL midlock_rst got gnt=%b lk=%b own=%0d want 0000/1/3", gnt, locked, owner); end
      drive(1'b0, 4'b1111, 4'b0000, pat());
      n_checks++;
      if (locked !== 1'b0 || q !== 8'h00 || gnt !== 4'b0001)
         begin n_fail++; $display("FAIL midlock_after got lk=%b q=%h gnt=%b want 0/00/0001", locked, q, gnt); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 39) == 0), N'($urandom), N'($urandom), ($urandom));
         n_checks++;
         if (gnt !== exp_gnt || $countones(gnt) > 1)
            begin n_fail++; $display("FAIL rand_gnt[%0d] got %b want %b", c, gnt, exp_gnt); end
         n_checks++;
         if (q !== m_q || q_valid !== m_qv || owner !== PW'(m_owner) || locked !== m_locked)
            begin
               n_fail++;
               $display("FAIL rand_state[%0d] got q=%h qv=%b own=%0d lk=%b want %h/%b/%0d/%b",
                        c, q, q_valid, owner, locked, m_q, m_qv, m_owner, m_locked);
            end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_sparse();
      test_lock_session();
      test_lock_release();
      test_reset_mid_lock();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

- Round-robin write arbiter for one shared W-bit storage register, built from synchronous-reset D flip-flops.
- Up to N requesters compete for the register; at most one write is granted per cycle.
- A granted requester may lock the register for a bounded burst of consecutive writes.
- Sits between requester logic and any consumer of the shared register value (`q`, `q_valid`).

## Interface
Parameters:
- N, 4, number of requesters (≥2)
- W, 8, data width of shared register
- MAX_HOLD, 4, max consecutive grants in one lock session (1 disables locking)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  N  per-requester write request
- lock  input  N  per-requester lock request (meaningful only with req)
- wdata  input  N*W  requester i data in bits [i*W +: W]
- gnt  output  N  one-hot grant, combinational, same cycle as req
- q  output  W  shared register contents
- q_valid  output  1  one-cycle pulse, q updated at last edge
- owner  output  clog2(N)  index of last granted requester
- locked  output  1  high while in LOCKED state

## Operation
- Reset values: q=0, q_valid=0, owner=0, locked=0, state=IDLE, ptr=0, hold_cnt=0; gnt forced 0 while reset high.
- State: ptr (round-robin pointer, clog2(N) bits), hold_cnt (clog2(MAX_HOLD+1) bits), FSM {IDLE, LOCKED}.
- IDLE:
  - Winner = first i with req[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
  - gnt[winner]=1.
  - At edge: q<=wdata[winner], q_valid<=1, owner<=winner, ptr<=(winner+1) mod N.
  - If lock[winner]=1 and MAX_HOLD>1: state<=LOCKED, hold_cnt<=1.
  - No req: gnt=0, q holds, q_valid<=0, no state change.
- LOCKED:
  - Only owner is eligible; all other req ignored. ptr stays at owner+1.
  - req[owner]=1: gnt[owner]=1, write as above, hold_cnt<=hold_cnt+1. Stay LOCKED iff lock[owner]=1 and hold_cnt+1<MAX_HOLD; else state<=IDLE, hold_cnt<=0.
  - req[owner]=0: no grant, q_valid<=0, state<=IDLE, hold_cnt<=0.
- Lock session = at most MAX_HOLD consecutive grants to one requester, counting the initial IDLE grant.
- Forced release: the next IDLE arbitration starts at owner+1, so the former owner has lowest priority.
- gnt is one-hot or zero in every cycle; never more than one bit set.
- lock without req has no effect.
- wdata of non-granted requesters is ignored.

## Timing
- Grant latency: 0 cycles (gnt combinational from req, state, ptr).
- Data latency: q and q_valid update at the edge closing the grant cycle (1 cycle).
- q_valid high exactly in cycles following a grant cycle; back-to-back grants give continuous q_valid.
- Synchronous reset overrides all activity at its edge, including mid-lock. The cycle after reset deasserts arbitrates from ptr=0 in IDLE.
- A requester dropping req in the same cycle its grant would occur receives no grant; no retraction is needed.
- hold_cnt never exceeds MAX_HOLD; no wrap.
- ptr wraps N-1 → 0.

## Test plan
- Reset with req=4'b1111 held 2 cycles → gnt=0 throughout; then q=0, q_valid=0, owner=0, locked=0.
- N=4, req=4'b1111, lock=0, wdata[i]=8'h10+i → gnt cycles 0001, 0010, 0100, 1000, 0001; q one cycle later 8'h10, 8'h11, 8'h12, 8'h13, 8'h10; q_valid continuously 1.
- From ptr=0, req=4'b0100 one cycle → gnt=0100, owner=2, ptr=3. Then req=4'b1010 → gnt 1000 then 0010.
- MAX_HOLD=4, req=4'b1111, lock=4'b0010 after ptr reaches 1 → four consecutive gnt=0010 with locked=1 for cycles 2–4. Then gnt=0100, locked=0.
- Owner 1 in LOCKED drops lock with req high after 2 grants → third grant still 0010, then IDLE. Next gnt=0100 if req[2] set. Case where owner drops req instead → that cycle gnt=0, q_valid=0, then IDLE.
- Reset asserted during LOCKED (owner=3, hold_cnt=2) with req=4'b1111 → after release: locked=0, q=0, first gnt=0001.
